// File: rtl/cache_trace_pkg.sv
// Shared trace command encodings and the op-code to cache routing rule
// used by the dispatcher front-end.
package cache_trace_pkg;

  localparam int unsigned DEFAULT_OP_W = 4;

  typedef enum logic [DEFAULT_OP_W-1:0] {
    READ_D  = 4'd0,
    WRITE_D = 4'd1,
    FETCH_I = 4'd2,
    INVAL   = 4'd3,
    SNOOP   = 4'd4,
    CLEAR   = 4'd8,
    PRINT   = 4'd9
  } op_e;

  typedef enum logic [1:0] {ROUTE_I, ROUTE_D, ROUTE_BOTH, ROUTE_DROP} route_e;

  function automatic route_e route_of(input int unsigned op);
    route_e r;
    case (op)
      int'(FETCH_I):                                         r = ROUTE_I;
      int'(READ_D), int'(WRITE_D), int'(INVAL), int'(SNOOP): r = ROUTE_D;
      int'(CLEAR), int'(PRINT):                              r = ROUTE_BOTH;
      default:                                               r = ROUTE_DROP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cache_request_dispatcher_fifo.sv
// Command FIFO: power-of-two depth, extra pointer bit distinguishes full from empty.
module cmd_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cache_request_dispatcher.sv
// Buffers trace commands and issues them in order to the I/D caches over
// valid/ready, splitting broadcast ops across both sides.
module cache_request_dispatcher
  import cache_trace_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = cache_trace_pkg::DEFAULT_OP_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              i_valid,
  input  logic              i_ready,
  output logic [OP_W-1:0]   i_op,
  output logic [ADDR_W-1:0] i_addr,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [OP_W-1:0]   d_op,
  output logic [ADDR_W-1:0] d_addr,
  output logic              idle,
  output logic [CNT_W-1:0]  i_count,
  output logic [CNT_W-1:0]  d_count,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic {ISSUE, BCAST} state_e;

  state_e            state, state_n;
  logic              i_done, i_done_n, d_done, d_done_n;
  logic              full, empty, pop;
  logic              inc_i, inc_d, inc_drop;
  logic [OP_W+ADDR_W-1:0] head;
  logic [OP_W-1:0]   head_op;
  logic [ADDR_W-1:0] head_addr;
  route_e            route;

  cmd_fifo #(.WIDTH(OP_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .din   ({cmd_op, cmd_addr}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign cmd_ready = !full && !reset;
  assign head_op   = head[ADDR_W +: OP_W];
  assign head_addr = head[ADDR_W-1:0];
  assign route     = route_of(32'(head_op));
  assign i_op      = head_op;
  assign i_addr    = head_addr;
  assign d_op      = head_op;
  assign d_addr    = head_addr;
  assign idle      = empty && (state == ISSUE);

  always_comb begin
    state_n  = state;
    i_done_n = i_done;
    d_done_n = d_done;
    i_valid  = 1'b0;
    d_valid  = 1'b0;
    pop      = 1'b0;
    inc_i    = 1'b0;
    inc_d    = 1'b0;
    inc_drop = 1'b0;
    if (!empty) begin
      case (route)
        ROUTE_I: begin
          i_valid = 1'b1;
          pop     = i_ready;
          inc_i   = i_ready;
        end
        ROUTE_D: begin
          d_valid = 1'b1;
          pop     = d_ready;
          inc_d   = d_ready;
        end
        ROUTE_DROP: begin
          pop      = 1'b1;
          inc_drop = 1'b1;
        end
        ROUTE_BOTH: begin
          if (state == ISSUE) begin
            i_valid = 1'b1;
            d_valid = 1'b1;
            inc_i   = i_ready;
            inc_d   = d_ready;
            if (i_ready && d_ready) begin
              pop = 1'b1;
            end else if (i_ready || d_ready) begin
              i_done_n = i_ready;
              d_done_n = d_ready;
              state_n  = BCAST;
            end
          end else begin
            // Only the side not yet served keeps its request up.
            i_valid = !i_done;
            d_valid = !d_done;
            if ((i_valid && i_ready) || (d_valid && d_ready)) begin
              pop      = 1'b1;
              inc_i    = i_valid;
              inc_d    = d_valid;
              i_done_n = 1'b0;
              d_done_n = 1'b0;
              state_n  = ISSUE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ISSUE;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      state  <= state_n;
      i_done <= i_done_n;
      d_done <= d_done_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_count    <= '0;
      d_count    <= '0;
      drop_count <= '0;
    end else begin
      if (inc_i && i_count != '1)       i_count    <= i_count + 1'b1;
      if (inc_d && d_count != '1)       d_count    <= d_count + 1'b1;
      if (inc_drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_request_dispatcher.sv
// Directed bench for cache_request_dispatcher: vector table plus multi-cycle sequences.
module tb_cache_request_dispatcher;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic        i_valid, i_ready, d_valid, d_ready, idle;
  logic [3:0]  i_op, d_op;
  logic [31:0] i_addr, d_addr;
  logic [15:0] i_count, d_count, drop_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cache_request_dispatcher #(.ADDR_W(32), .OP_W(4), .DEPTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_addr(i_addr),
    .d_valid(d_valid), .d_ready(d_ready), .d_op(d_op), .d_addr(d_addr),
    .idle(idle), .i_count(i_count), .d_count(d_count), .drop_count(drop_count)
  );

  typedef struct {
    logic cv; logic [3:0] op; logic [31:0] addr; logic ir; logic dr;
    logic cr; logic iv; logic [3:0] iop; logic [31:0] ia;
    logic dv; logic [3:0] dop; logic [31:0] da; logic idl;
    int ic; int dc; int drc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n, p, ivc, dvc;
    bit seen_bcast;
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'hdead;
    i_ready = 1'b1; d_ready = 1'b1;

    // Reset held with a command offered: nothing may be accepted.
    #2;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_i_valid", i_valid, 0);
      chk("rst_d_valid", d_valid, 0);
      tick();
    end
    reset = 1'b0; cmd_valid = 1'b0;
    settle();
    chk("rst_idle", idle, 1);
    chk("rst_cmd_ready_after", cmd_ready, 1);
    chk("rst_counts", {i_count, d_count, drop_count}, 0);
    chk("rst_no_push_valid", i_valid | d_valid, 0);

    //           cv  op    addr        ir dr  cr iv iop  ia        dv dop  da        idl ic dc drc
    vecs[0]  = '{1, 4'd2, 32'h100,    1, 1,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   1,  0, 0, 0};
    vecs[1]  = '{1, 4'd0, 32'h200,    1, 1,  1, 1, 4'd2, 32'h100,  0, 4'd0, 32'h0,   0,  0, 0, 0};
    vecs[2]  = '{0, 4'd0, 32'h0,      1, 1,  1, 0, 4'd0, 32'h0,    1, 4'd0, 32'h200, 0,  1, 0, 0};
    vecs[3]  = '{0, 4'd0, 32'h0,      1, 1,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   1,  1, 1, 0};
    vecs[4]  = '{1, 4'd0, 32'h10,     1, 1,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   1,  1, 1, 0};
    vecs[5]  = '{1, 4'd7, 32'h55,     1, 1,  1, 0, 4'd0, 32'h0,    1, 4'd0, 32'h10,  0,  1, 1, 0};
    vecs[6]  = '{1, 4'd0, 32'h20,     1, 1,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   0,  1, 2, 0};
    vecs[7]  = '{0, 4'd0, 32'h0,      1, 1,  1, 0, 4'd0, 32'h0,    1, 4'd0, 32'h20,  0,  1, 2, 1};
    vecs[8]  = '{0, 4'd0, 32'h0,      1, 1,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   1,  1, 3, 1};
    vecs[9]  = '{1, 4'd3, 32'h300,    1, 0,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   1,  1, 3, 1};
    vecs[10] = '{0, 4'd0, 32'h0,      1, 0,  1, 0, 4'd0, 32'h0,    1, 4'd3, 32'h300, 0,  1, 3, 1};
    vecs[11] = '{0, 4'd0, 32'h0,      1, 1,  1, 0, 4'd0, 32'h0,    1, 4'd3, 32'h300, 0,  1, 3, 1};
    vecs[12] = '{0, 4'd0, 32'h0,      1, 1,  1, 0, 4'd0, 32'h0,    0, 4'd0, 32'h0,   1,  1, 4, 1};

    foreach (vecs[k]) begin
      cmd_valid = vecs[k].cv; cmd_op = vecs[k].op; cmd_addr = vecs[k].addr;
      i_ready = vecs[k].ir; d_ready = vecs[k].dr;
      settle();
      chk($sformatf("v%0d_cmd_ready", k), cmd_ready, vecs[k].cr);
      chk($sformatf("v%0d_i_valid", k), i_valid, vecs[k].iv);
      chk($sformatf("v%0d_d_valid", k), d_valid, vecs[k].dv);
      chk($sformatf("v%0d_idle", k), idle, vecs[k].idl);
      chk($sformatf("v%0d_i_count", k), i_count, vecs[k].ic);
      chk($sformatf("v%0d_d_count", k), d_count, vecs[k].dc);
      chk($sformatf("v%0d_drop_count", k), drop_count, vecs[k].drc);
      if (vecs[k].iv) begin
        chk($sformatf("v%0d_i_op", k), i_op, vecs[k].iop);
        chk($sformatf("v%0d_i_addr", k), i_addr, vecs[k].ia);
      end
      if (vecs[k].dv) begin
        chk($sformatf("v%0d_d_op", k), d_op, vecs[k].dop);
        chk($sformatf("v%0d_d_addr", k), d_addr, vecs[k].da);
      end
      tick();
    end

    // Broadcast split: D accepts first, I stalls four cycles, following op1 waits.
    do_reset();
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_addr = 32'h0; i_ready = 1'b0; d_ready = 1'b1;
    tick();
    cmd_op = 4'd1; cmd_addr = 32'h44;
    ivc = 0; dvc = 0;
    for (int c = 0; c < 5; c++) begin
      i_ready = (c == 4);
      settle();
      if (i_valid) ivc++;
      if (d_valid) dvc++;
      if (c == 0) chk("bc_both_valid", {i_valid, d_valid}, 2'b11);
      else begin
        chk("bc_i_held", i_valid, 1);
        chk("bc_i_addr", i_addr, 32'h0);
        chk("bc_d_dropped", d_valid, 0);
      end
      tick();
      cmd_valid = 1'b0;
    end
    settle();
    chk("bc_i_valid_cycles", ivc, 5);
    chk("bc_d_valid_cycles", dvc, 1);
    chk("bc_counts", {i_count, d_count}, {16'd1, 16'd1});
    chk("bc_next_d_valid", d_valid, 1);
    chk("bc_next_d_op", d_op, 4'd1);
    chk("bc_next_d_addr", d_addr, 32'h44);
    chk("bc_next_i_valid", i_valid, 0);

    // Fill past DEPTH with stalled sinks, then drain and check order.
    do_reset();
    i_ready = 1'b0; d_ready = 1'b0; cmd_op = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h1000 + k;
      settle();
      chk($sformatf("fill%0d_cmd_ready", k), cmd_ready, 1);
      tick();
    end
    cmd_addr = 32'h1008;
    settle();
    chk("full_cmd_ready", cmd_ready, 0);
    tick();
    settle();
    chk("full_held_cmd_ready", cmd_ready, 0);
    chk("full_head_addr", d_addr, 32'h1000);
    d_ready = 1'b1;
    settle();
    chk("full_ready_ignores_pop", cmd_ready, 0);
    n = 0; p = 8;
    for (int c = 0; c < 40 && n < 10; c++) begin
      cmd_valid = (p < 10); cmd_addr = 32'h1000 + p;
      settle();
      if (d_valid) begin
        chk($sformatf("drain%0d_addr", n), d_addr, 32'h1000 + n);
        n++;
      end
      if (cmd_valid && cmd_ready) p++;
      tick();
    end
    cmd_valid = 1'b0;
    settle();
    chk("drain_all_emerged", n, 10);
    chk("drain_d_count", d_count, 10);
    chk("drain_idle", idle, 1);

    // Reset with a broadcast half-done and three entries queued.
    do_reset();
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_addr = 32'h0; i_ready = 1'b0; d_ready = 1'b1;
    tick();
    cmd_op = 4'd0; cmd_addr = 32'h1;
    tick();
    cmd_addr = 32'h2;
    tick();
    cmd_valid = 1'b0;
    settle();
    seen_bcast = i_valid && !d_valid;
    chk("rst6_bcast_pending", seen_bcast, 1);
    chk("rst6_not_idle", idle, 0);
    reset = 1'b1;
    tick();
    settle();
    chk("rst6_idle", idle, 1);
    chk("rst6_valids", {i_valid, d_valid}, 0);
    chk("rst6_counts", {i_count, d_count, drop_count}, 0);
    reset = 1'b0;
    settle();
    chk("rst6_cmd_ready", cmd_ready, 1);
    tick();
    settle();
    chk("rst6_still_idle", idle, 1);
    chk("rst6_no_valid", {i_valid, d_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
